// File: rtl/intersection_controller_if.sv
// Signal bundle between the intersection phase sequencer and its environment.
// The master side supplies the demand inputs. The slave side presents the lamp drives.
interface intersection_controller_if;
  logic       ew_sensor;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output ew_sensor,
    output ped_req,
    input  ns_light,
    input  ew_light,
    input  walk,
    input  phase
  );

  modport slave (
    input  ew_sensor,
    input  ped_req,
    output ns_light,
    output ew_light,
    output walk,
    output phase
  );
endinterface

// File: rtl/intersection_controller.sv
// Two-road intersection phase sequencer.
// North-south green is the resting phase. Side-road vehicle demand or a latched
// pedestrian request moves the lights through yellow and all-red clearance.
// The sequence then serves the walk phase and/or east-west green before returning.
// Light outputs are {red, yellow, green}, one-hot, and decoded from the state only.
module intersection_controller #(
  parameter int GREEN_MIN    = 8,
  parameter int EW_GREEN_MIN = 4,
  parameter int EW_GREEN_MAX = 12,
  parameter int YELLOW       = 3,
  parameter int ALL_RED      = 2,
  parameter int WALK         = 6,
  parameter int CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  intersection_controller_if.slave    bus
);

  // Phase encodings, also presented on the debug phase output.
  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED_A = 3'd2;
  localparam logic [2:0] WALK_PH   = 3'd3;
  localparam logic [2:0] EW_GREEN  = 3'd4;
  localparam logic [2:0] EW_YELLOW = 3'd5;
  localparam logic [2:0] ALL_RED_B = 3'd6;

  // Lamp patterns, {red, yellow, green}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Final timer value of each phase. A duration of 2^CNT_W still fits because only duration-1 is stored.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] EW_MIN_LAST = CNT_W'(EW_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] EW_MAX_LAST = CNT_W'(EW_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] timer;
  logic             ew_pending;
  logic             ped_pending;
  logic             enter_ew;
  logic             enter_walk;
  logic             state_change;
  logic [2:0]       ns_raw;
  logic [2:0]       ew_raw;
  logic             walk_raw;
  logic             conflict;

  assign state_change = (next_state != state);
  assign enter_ew     = (next_state == EW_GREEN) && (state != EW_GREEN);
  assign enter_walk   = (next_state == WALK_PH)  && (state != WALK_PH);

  // Next-phase selection from the current timer and the registered request latches.
  always_comb begin
    next_state = state;
    case (state)
      NS_GREEN: begin
        if ((timer == GREEN_LAST) && (ew_pending || ped_pending))
          next_state = NS_YELLOW;
      end
      NS_YELLOW: begin
        if (timer == YELLOW_LAST)
          next_state = ALL_RED_A;
      end
      ALL_RED_A: begin
        if (timer == ALLRED_LAST) begin
          if (ped_pending)
            next_state = WALK_PH;
          else if (ew_pending)
            next_state = EW_GREEN;
          else
            next_state = NS_GREEN;
        end
      end
      WALK_PH: begin
        if (timer == WALK_LAST)
          next_state = ew_pending ? EW_GREEN : NS_GREEN;
      end
      EW_GREEN: begin
        if ((timer == EW_MAX_LAST) || ((timer >= EW_MIN_LAST) && !bus.ew_sensor))
          next_state = EW_YELLOW;
      end
      EW_YELLOW: begin
        if (timer == YELLOW_LAST)
          next_state = ALL_RED_B;
      end
      ALL_RED_B: begin
        if (timer == ALLRED_LAST)
          next_state = NS_GREEN;
      end
      default: next_state = NS_GREEN;
    endcase
  end

  // The phase register is the only source of the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= NS_GREEN;
    else
      state <= next_state;
  end

  // Phase timer: restarts on every change and holds at the NS minimum so an idle main road never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      timer <= '0;
    else if (state_change)
      timer <= '0;
    else if ((state == NS_GREEN) && (timer == GREEN_LAST))
      timer <= timer;
    else
      timer <= timer + CNT_W'(1);
  end

  // Side-road demand latch. A vehicle seen outside EW green is remembered until EW green is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ew_pending <= 1'b0;
    else if (enter_ew)
      ew_pending <= 1'b0;
    else if (bus.ew_sensor && (state != EW_GREEN))
      ew_pending <= 1'b1;
  end

  // Pedestrian latch. Presses during the walk phase are ignored because the walk is already being served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ped_pending <= 1'b0;
    else if (enter_walk)
      ped_pending <= 1'b0;
    else if (bus.ped_req && (state != WALK_PH))
      ped_pending <= 1'b1;
  end

  // Moore lamp decode. Unlisted encodings show all red as the safe choice.
  always_comb begin
    ns_raw   = LAMP_RED;
    ew_raw   = LAMP_RED;
    walk_raw = 1'b0;
    case (state)
      NS_GREEN:  ns_raw = LAMP_GREEN;
      NS_YELLOW: ns_raw = LAMP_YELLOW;
      EW_GREEN:  ew_raw = LAMP_GREEN;
      EW_YELLOW: ew_raw = LAMP_YELLOW;
      WALK_PH:   walk_raw = 1'b1;
      default: begin
        ns_raw   = LAMP_RED;
        ew_raw   = LAMP_RED;
        walk_raw = 1'b0;
      end
    endcase
  end

  // Last-line interlock: if the decode ever produced conflicting indications, force everything to red.
  always_comb begin
    conflict     = ((ns_raw != LAMP_RED) && (ew_raw != LAMP_RED)) ||
                   (walk_raw && ((ns_raw != LAMP_RED) || (ew_raw != LAMP_RED)));
    bus.ns_light = conflict ? LAMP_RED : ns_raw;
    bus.ew_light = conflict ? LAMP_RED : ew_raw;
    bus.walk     = conflict ? 1'b0     : walk_raw;
    bus.phase    = state;
  end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Phase sequencer for a two-road intersection: north-south (main) and east-west (side) lights plus a pedestrian walk signal. NS green is the default. EW demand from a vehicle sensor, or a latched pedestrian request, moves the intersection through yellow, all-red, walk and EW-green phases. Each phase has a fixed minimum, maximum or exact duration, and the block guarantees that conflicting greens are never shown. It drives the per-road 3-bit light outputs that the existing traffic-light logic uses and sits directly below the top level.

## Interface
- GREEN_MIN, 8, minimum NS green cycles before a request is served
- EW_GREEN_MIN, 4, minimum EW green cycles
- EW_GREEN_MAX, 12, maximum EW green cycles
- YELLOW, 3, yellow cycles (both roads)
- ALL_RED, 2, all-red clearance cycles
- WALK, 6, pedestrian walk cycles
- CNT_W, 8, phase-timer width; every duration is in 1..2^CNT_W, and EW_GREEN_MIN ≤ EW_GREEN_MAX
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; reset=0 clears the block immediately
- ew_sensor  in  1  side-road vehicle present (level)
- ped_req  in  1  pedestrian button (pulse or level)
- ns_light  out  3  {red, yellow, green}, one-hot
- ew_light  out  3  {red, yellow, green}, one-hot
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding (debug)

## Operation
- States and their `phase` codes: NS_GREEN=0, NS_YELLOW=1, ALL_RED_A=2, WALK_PH=3, EW_GREEN=4, EW_YELLOW=5, ALL_RED_B=6. Code 7 is illegal and recovers to NS_GREEN.
- Outputs are Moore, decoded from the state register only:
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - All-red and walk states: ns=ew=100.
  - walk=1 only in WALK_PH.
- Request latches:
  - ew_pending sets on ew_sensor=1 in any state except EW_GREEN, and clears on entry to EW_GREEN.
  - ped_pending sets on ped_req=1 in any state except WALK_PH, and clears on entry to WALK_PH. ped_req during WALK_PH is ignored.
- Phase timer: resets to 0 on every state change and increments each cycle otherwise. It saturates in NS_GREEN at GREEN_MIN-1.
- Transitions are evaluated at an edge, using the current timer value and the registered pendings:
  - NS_GREEN → NS_YELLOW when timer == GREEN_MIN-1 and (ew_pending | ped_pending). Otherwise NS_GREEN holds indefinitely.
  - NS_YELLOW → ALL_RED_A at timer == YELLOW-1.
  - ALL_RED_A at timer == ALL_RED-1 goes to WALK_PH if ped_pending, else EW_GREEN if ew_pending, else NS_GREEN.
  - WALK_PH at timer == WALK-1 goes to EW_GREEN if ew_pending, else NS_GREEN.
  - EW_GREEN → EW_YELLOW at timer == EW_GREEN_MAX-1, or earlier at timer ≥ EW_GREEN_MIN-1 with ew_sensor=0 (gap-out).
  - EW_YELLOW → ALL_RED_B at timer == YELLOW-1.
  - ALL_RED_B → NS_GREEN at timer == ALL_RED-1.
- Simultaneous EW and pedestrian demand: WALK_PH is served first, then EW_GREEN.
- Safety invariant: at most one road shows non-red, and walk=1 implies both roads are red.

## Timing
- In reset (reset=0): state NS_GREEN, timer=0, both pendings 0, ns_light=001, ew_light=100, walk=0, phase=0.
- Assertion is asynchronous. Release is synchronous to the next rising edge.
- Edge numbering: edge k is the k-th rising edge after reset release, counting from 0.
- Each timed state is visible for exactly its parameter's number of cycles.
- Request latency is one cycle. An input sampled at edge k sets its pending at edge k. The earliest NS_GREEN exit is at edge max(k+1, GREEN_MIN-1), provided NS_GREEN was entered at or before edge 0.
- Reset asserted mid-phase (including EW_GREEN or WALK_PH) returns to NS_GREEN immediately and discards all pending requests.
- The timer never wraps: every compare terminates the state before overflow.

## Test plan
- No requests for 100 cycles after release → ns_light=001, ew_light=100, walk=0, phase=0 throughout.
- ew_sensor=1 held from edge 0 (default parameters) → NS_YELLOW after edge 7, ALL_RED_A after 10, EW_GREEN after 12, EW_YELLOW after 24 (max green), ALL_RED_B after 27, NS_GREEN after 29; the cycle then repeats.
- ew_sensor pulsed for one cycle at edge 0 → EW_GREEN after edge 12, gap-out to EW_YELLOW after edge 16, NS_GREEN after edge 21.
- ped_req pulsed at edge 2 → NS_YELLOW after edge 7, WALK_PH (walk=1, ns=ew=100) after edge 12, NS_GREEN after edge 18 with walk=0. A second ped_req at edge 14 is ignored.
- ped_req and ew_sensor both pulsed at edge 0 → WALK_PH after edge 12, EW_GREEN after edge 18, EW_YELLOW after edge 22.
- reset driven low mid-EW_GREEN (e.g. 3 ns after edge 15) → outputs go to ns=001, ew=100, walk=0 before the next edge. After release with no requests, NS_GREEN holds. A continuous checker flags any cycle with both roads non-red, or walk=1 while either road is non-red.
